sa_11: RTL



---
 rtl/sa_11.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sa_11.sv
// Switch allocator and registered output stage for mesh router node (1,1).
// Define SA_RR_ARB_EN for round-robin arbitration per output; otherwise fixed priority (lowest input wins).
module sa_11 #(
    parameter int DATASIZE = 40,
    parameter int NPORT    = 5
) (
    input  logic                      sa_clk,
    input  logic                      rst,
    input  logic [NPORT*DATASIZE-1:0] in_data,
    input  logic [NPORT*4-1:0]        in_dir,
    input  logic [NPORT-1:0]          in_valid,
    output logic [NPORT-1:0]          in_ready,
    output logic [NPORT*DATASIZE-1:0] out_data,
    output logic [NPORT-1:0]          out_valid,
    input  logic [NPORT-1:0]          out_ready,
    output logic                      drop_pulse
);

    logic [NPORT-1:0]    req [NPORT];   // req[o][i]: input i wants output o
    logic [NPORT-1:0]    gnt [NPORT];   // gnt[o][i]: input i wins output o
    logic [DATASIZE-1:0] gnt_data [NPORT];
    logic [NPORT-1:0]    illegal;
    logic [NPORT-1:0]    out_free;
    logic [NPORT-1:0]    out_load;
    logic [NPORT-1:0]    in_granted;

    function automatic logic [NPORT-1:0] pick_fixed(input logic [NPORT-1:0] r);
        logic [NPORT-1:0] g;
        logic             found;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            if (!found && r[k]) begin
                g[k]  = 1'b1;
                found = 1'b1;
            end
        end
        return g;
    endfunction

`ifdef SA_RR_ARB_EN
    logic [2:0] ptr     [NPORT];
    logic [2:0] gnt_idx [NPORT];

    // Search starts at the pointer and wraps from the last input back to input 0.
    function automatic logic [NPORT-1:0] pick_rr(input logic [NPORT-1:0] r, input logic [2:0] p);
        logic [NPORT-1:0] g;
        logic             found;
        int               idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            idx = (int'(p) + k) % NPORT;
            if (!found && r[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction
`endif

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        illegal  = '0;
        out_free = '0;
        for (int o = 0; o < NPORT; o++) begin
            req[o]      = '0;
            out_free[o] = !out_valid[o] || out_ready[o];
        end
        for (int i = 0; i < NPORT; i++) begin
            illegal[i] = in_valid[i] && (in_dir[i*4 +: 4] > 4'd4);
            for (int o = 0; o < NPORT; o++) begin
                req[o][i] = in_valid[i] && (in_dir[i*4 +: 4] == 4'(o));
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
`ifdef SA_RR_ARB_EN
            gnt[o] = out_free[o] ? pick_rr(req[o], ptr[o]) : '0;
`else
            gnt[o] = out_free[o] ? pick_fixed(req[o]) : '0;
`endif
        end
    end

    always_comb begin
        in_granted = '0;
        out_load   = '0;
        for (int o = 0; o < NPORT; o++) begin
            gnt_data[o] = '0;
            out_load[o] = |gnt[o];
            for (int i = 0; i < NPORT; i++) begin
                if (gnt[o][i]) begin
                    gnt_data[o]   = in_data[i*DATASIZE +: DATASIZE];
                    in_granted[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready = rst ? '0 : (in_granted | illegal);

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge sa_clk or posedge rst) begin
        if (rst) begin
            out_valid  <= '0;
            out_data   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= |illegal;
            for (int o = 0; o < NPORT; o++) begin
                if (out_load[o]) begin
                    out_valid[o]                      <= 1'b1;
                    out_data[o*DATASIZE +: DATASIZE]  <= gnt_data[o];
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

`ifdef SA_RR_ARB_EN
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            gnt_idx[o] = '0;
            for (int i = 0; i < NPORT; i++) begin
                if (gnt[o][i]) gnt_idx[o] = 3'(i);
            end
        end
    end

    // Pointer moves only on a grant, to the input after the winner, wrapping 4 -> 0.
    always_ff @(posedge sa_clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NPORT; o++) ptr[o] <= '0;
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                if (out_load[o]) ptr[o] <= (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
            end
        end
    end
`endif

endmodule
